// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle between the pipeline and the branch predictor.
// master = pipeline (drives lookup PC and resolved branch info), slave = predictor.
interface branch_predictor_if #(
    parameter int PC_WIDTH = 32
);
    logic [PC_WIDTH-1:0] if_pc;
    logic                pred_taken;
    logic [PC_WIDTH-1:0] pred_target;
    logic                ex_branch;
    logic                ex_stall;
    logic [PC_WIDTH-1:0] ex_pc;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] pc_plus_imm;
    logic                ex_pred_taken;
    logic [PC_WIDTH-1:0] ex_pred_target;
    logic                mispredict;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic [31:0]         branch_count;
    logic [31:0]         mispredict_count;

    modport master (
        output if_pc, ex_branch, ex_stall, ex_pc, branch_taken, pc_plus_imm,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc,
               branch_count, mispredict_count
    );

    modport slave (
        input  if_pc, ex_branch, ex_stall, ex_pc, branch_taken, pc_plus_imm,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: predicts in IF, resolves and
// trains in EX, and keeps branch / mispredict statistics.
module branch_predictor #(
    parameter int PC_WIDTH = 32,
    parameter int IDX_BITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bus
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = PC_WIDTH - IDX_BITS - 2;

    logic [ENTRIES-1:0] valid_vec;
    logic [TAG_W-1:0]    tag_vec    [ENTRIES];
    logic [PC_WIDTH-1:0] target_vec [ENTRIES];
    logic [1:0]          ctr_vec    [ENTRIES];

    logic [IDX_BITS-1:0] if_idx;
    logic [IDX_BITS-1:0] ex_idx;
    logic [TAG_W-1:0]    if_tag;
    logic [TAG_W-1:0]    ex_tag;
    logic                if_hit;
    logic                ex_hit;
    logic [1:0]          ex_ctr;
    logic [1:0]          ctr_next;
    logic                train_en;
    logic                mispredict;
    logic [31:0]         branch_count_reg;
    logic [31:0]         mispredict_count_reg;
    logic                unused_pc_lsbs;

    assign if_idx = bus.if_pc[IDX_BITS+1:2];
    assign if_tag = bus.if_pc[PC_WIDTH-1:IDX_BITS+2];
    assign ex_idx = bus.ex_pc[IDX_BITS+1:2];
    assign ex_tag = bus.ex_pc[PC_WIDTH-1:IDX_BITS+2];
    assign unused_pc_lsbs = ^{bus.if_pc[1:0], bus.ex_pc[1:0]};

    // IF lookup reads the current table; an EX update in the same cycle is not bypassed.
    assign if_hit          = valid_vec[if_idx] && (tag_vec[if_idx] == if_tag);
    assign bus.pred_taken  = if_hit && ctr_vec[if_idx][1];
    assign bus.pred_target = bus.pred_taken ? target_vec[if_idx]
                                            : bus.if_pc + PC_WIDTH'(4);

    assign ex_hit = valid_vec[ex_idx] && (tag_vec[ex_idx] == ex_tag);
    assign ex_ctr = ctr_vec[ex_idx];

    always_comb begin
        ctr_next = ex_ctr;
        if (bus.branch_taken) begin
            if (ex_ctr != 2'b11) ctr_next = ex_ctr + 2'b01;
        end else begin
            if (ex_ctr != 2'b00) ctr_next = ex_ctr - 2'b01;
        end
    end

    assign mispredict = bus.ex_branch &&
                        ((bus.branch_taken != bus.ex_pred_taken) ||
                         (bus.branch_taken && (bus.pc_plus_imm != bus.ex_pred_target)));
    assign bus.mispredict  = mispredict;
    assign bus.redirect_pc = (bus.ex_branch && bus.branch_taken) ? bus.pc_plus_imm
                                                                 : bus.ex_pc + PC_WIDTH'(4);

    assign train_en = bus.ex_branch && !bus.ex_stall;

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic                valid_reg;
            logic [TAG_W-1:0]    tag_reg;
            logic [PC_WIDTH-1:0] target_reg;
            logic [1:0]          ctr_reg;
            logic                sel;

            assign sel = train_en && (ex_idx == IDX_BITS'(gi));

            // Not-taken misses never allocate, so they cannot evict an aliasing branch.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    ctr_reg    <= 2'b01;
                end else if (sel) begin
                    if (ex_hit) begin
                        ctr_reg <= ctr_next;
                        if (bus.branch_taken) target_reg <= bus.pc_plus_imm;
                    end else if (bus.branch_taken) begin
                        valid_reg  <= 1'b1;
                        tag_reg    <= ex_tag;
                        target_reg <= bus.pc_plus_imm;
                        ctr_reg    <= 2'b10;
                    end
                end
            end

            assign valid_vec[gi]  = valid_reg;
            assign tag_vec[gi]    = tag_reg;
            assign target_vec[gi] = target_reg;
            assign ctr_vec[gi]    = ctr_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count_reg     <= '0;
            mispredict_count_reg <= '0;
        end else if (train_en) begin
            branch_count_reg <= branch_count_reg + 32'd1;
            if (mispredict) mispredict_count_reg <= mispredict_count_reg + 32'd1;
        end
    end

    assign bus.branch_count     = branch_count_reg;
    assign bus.mispredict_count = mispredict_count_reg;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    branch_predictor_if #(.PC_WIDTH(32)) bus ();

    branch_predictor #(.PC_WIDTH(32), .IDX_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic [31:0] pc, input logic taken, input logic [31:0] imm,
                          input logic ptaken, input logic [31:0] ptarget);
        bus.ex_branch      = 1'b1;
        bus.ex_pc          = pc;
        bus.branch_taken   = taken;
        bus.pc_plus_imm    = imm;
        bus.ex_pred_taken  = ptaken;
        bus.ex_pred_target = ptarget;
    endtask

    task automatic ex_clear();
        bus.ex_branch     = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.ex_pred_taken = 1'b0;
    endtask

    task automatic chk_counts(input string tag, input logic [31:0] b, input logic [31:0] m);
        chk({tag, ".branch_count"}, bus.branch_count, b);
        chk({tag, ".mispredict_count"}, bus.mispredict_count, m);
    endtask

    task automatic chk_pred(input string tag, input logic [31:0] pc, input logic t,
                            input logic [31:0] tgt);
        bus.if_pc = pc;
        #1;
        chk({tag, ".pred_taken"}, {31'd0, bus.pred_taken}, {31'd0, t});
        chk({tag, ".pred_target"}, bus.pred_target, tgt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.if_pc = 32'h0;
        bus.ex_stall = 1'b0;
        bus.ex_pc = 32'h0;
        bus.pc_plus_imm = 32'h0;
        bus.ex_pred_target = 32'h0;
        ex_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk_pred("rst_0x100", 32'h100, 1'b0, 32'h104);
        chk_counts("rst", 32'd0, 32'd0);
        chk_pred("rst_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
        bus.ex_pc = 32'h200;
        #1;
        chk("idle.mispredict", {31'd0, bus.mispredict}, 32'd0);
        chk("idle.redirect", bus.redirect_pc, 32'h204);

        // First taken branch: mispredict, allocate; same-cycle IF sees old contents
        bus.if_pc = 32'h100;
        ex_set(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        chk("alloc.mispredict", {31'd0, bus.mispredict}, 32'd1);
        chk("alloc.redirect", bus.redirect_pc, 32'h80);
        chk("alloc.nobypass", {31'd0, bus.pred_taken}, 32'd0);
        tick();
        ex_clear();
        chk_pred("alloc.after", 32'h100, 1'b1, 32'h80);
        chk_counts("alloc", 32'd1, 32'd1);

        // Three correct taken predictions: counter 2 -> 3, saturates
        for (int i = 0; i < 3; i++) begin
            ex_set(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
            #1;
            chk("taken.mispredict", {31'd0, bus.mispredict}, 32'd0);
            tick();
        end
        ex_clear();
        chk_counts("taken3", 32'd4, 32'd1);

        // First not-taken: 3 -> 2, still predicted taken
        ex_set(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        #1;
        chk("nt1.mispredict", {31'd0, bus.mispredict}, 32'd1);
        chk("nt1.redirect", bus.redirect_pc, 32'h104);
        tick();
        ex_clear();
        chk_pred("nt1.after", 32'h100, 1'b1, 32'h80);
        chk_counts("nt1", 32'd5, 32'd2);

        // Second not-taken: 2 -> 1, now predicted not taken
        ex_set(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        tick();
        ex_clear();
        chk_pred("nt2.after", 32'h100, 1'b0, 32'h104);
        chk_counts("nt2", 32'd6, 32'd3);

        // Right direction, wrong target
        ex_set(32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
        #1;
        chk("tgt.mispredict", {31'd0, bus.mispredict}, 32'd1);
        chk("tgt.redirect", bus.redirect_pc, 32'h90);
        tick();
        ex_clear();
        chk_pred("tgt.after", 32'h100, 1'b1, 32'h90);
        chk_counts("tgt", 32'd7, 32'd4);

        // Not-taken miss on an aliasing PC does not evict
        ex_set(32'h140, 1'b0, 32'h200, 1'b0, 32'h144);
        #1;
        chk("alias_nt.mispredict", {31'd0, bus.mispredict}, 32'd0);
        chk("alias_nt.redirect", bus.redirect_pc, 32'h144);
        tick();
        ex_clear();
        chk_pred("alias_nt.0x100", 32'h100, 1'b1, 32'h90);
        chk_pred("alias_nt.0x140", 32'h140, 1'b0, 32'h144);
        chk_counts("alias_nt", 32'd8, 32'd4);

        // Taken miss on the aliasing PC replaces the entry
        ex_set(32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
        #1;
        chk("alias_t.mispredict", {31'd0, bus.mispredict}, 32'd1);
        tick();
        ex_clear();
        chk_pred("alias_t.0x100", 32'h100, 1'b0, 32'h104);
        chk_pred("alias_t.0x140", 32'h140, 1'b1, 32'h200);
        chk_counts("alias_t", 32'd9, 32'd5);

        // New entry starts at ctr=2: one not-taken drops it below threshold
        ex_set(32'h140, 1'b0, 32'h200, 1'b1, 32'h200);
        tick();
        ex_clear();
        chk_pred("alias_ctr2", 32'h140, 1'b0, 32'h144);
        chk_counts("alias_ctr2", 32'd10, 32'd6);

        // Stalled branch: mispredict visible, no training or counting until released
        ex_set(32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
        bus.ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall.mispredict", {31'd0, bus.mispredict}, 32'd1);
            tick();
        end
        chk_counts("stall", 32'd10, 32'd6);
        chk_pred("stall.pred", 32'h140, 1'b0, 32'h144);
        bus.ex_stall = 1'b0;
        tick();
        ex_clear();
        chk_pred("release.pred", 32'h140, 1'b1, 32'h200);
        chk_counts("release", 32'd11, 32'd7);

        // Asynchronous reset mid-cycle, with a training update pending
        ex_set(32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
        #2;
        rst = 1'b1;
        #1;
        chk_counts("arst", 32'd0, 32'd0);
        chk("arst.pred_taken", {31'd0, bus.pred_taken}, 32'd0);
        chk("arst.pred_target", bus.pred_target, 32'h144);
        tick();
        ex_clear();
        rst = 1'b0;
        #1;
        chk("arst_post.mispredict", {31'd0, bus.mispredict}, 32'd0);
        chk_pred("arst_post.pred", 32'h140, 1'b0, 32'h144);
        chk_counts("arst_post", 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor and misprediction resolver for the five-stage pipeline. In IF it predicts the next PC from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. In EX it consumes the resolved branch outcome and target from the branch unit, trains the tables, and raises a redirect on misprediction. It also keeps free-running branch and mispredict statistics.

## Interface
- PC_WIDTH, 32, PC width in bits
- IDX_BITS, 4, BTB index width; ENTRIES = 2^IDX_BITS = 16
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- IF_PC  in  PC_WIDTH  PC of instruction being fetched
- Pred_Taken  out  1  IF prediction: branch taken
- Pred_Target  out  PC_WIDTH  predicted next PC (BTB target if Pred_Taken, else IF_PC+4)
- EX_Branch  in  1  instruction in EX is a conditional branch
- EX_Stall  in  1  EX held this cycle; suppresses training and statistics
- EX_PC  in  PC_WIDTH  PC of the branch in EX
- Branch_Taken  in  1  resolved outcome from the branch unit
- PC_Plus_Imm  in  PC_WIDTH  resolved taken target
- EX_Pred_Taken  in  1  Pred_Taken piped with the branch from IF to EX
- EX_Pred_Target  in  PC_WIDTH  Pred_Target piped with the branch
- Mispredict  out  1  flush IF/ID and ID/EX, load Redirect_PC
- Redirect_PC  out  PC_WIDTH  correct next PC
- Branch_Count  out  32  retired conditional branches
- Mispredict_Count  out  32  mispredicted conditional branches

## Operation
- Entry fields: valid (1), tag (PC_WIDTH-IDX_BITS-2), target (PC_WIDTH), ctr (2).
- Index is PC[IDX_BITS+1:2]; tag is PC[PC_WIDTH-1:IDX_BITS+2]. PC[1:0] is ignored.
- IF lookup (combinational on IF_PC):
  - hit = valid && tag match.
  - Pred_Taken = hit && ctr[1].
  - Pred_Target = Pred_Taken ? target : IF_PC+4, computed modulo 2^PC_WIDTH.
- EX resolve (combinational), gated by EX_Branch:
  - Mispredict = EX_Branch && (Branch_Taken != EX_Pred_Taken || (Branch_Taken && PC_Plus_Imm != EX_Pred_Target)).
  - Redirect_PC = Branch_Taken ? PC_Plus_Imm : EX_PC+4.
  - When EX_Branch=0: Mispredict=0 and Redirect_PC=EX_PC+4.
  - Mispredict is not gated by EX_Stall. The pipeline control ignores it while stalled.
- Training at the clock edge when EX_Branch && !EX_Stall:
  - EX_PC hits the BTB:
    - ctr saturating +1 if taken, −1 if not taken; range 0..3.
    - If taken, target <= PC_Plus_Imm.
  - EX_PC misses and taken: allocate or overwrite the entry; valid=1, tag, target=PC_Plus_Imm, ctr=2'b10.
  - EX_PC misses and not taken: no allocation.
- Statistics at the same gated edge:
  - Branch_Count +1.
  - Mispredict_Count +1 if Mispredict.
  - Both wrap from 2^32−1 to 0.
- Only conditional branches are handled. JAL/JALR never assert EX_Branch and are never trained.

## Timing
- Reset values:
  - All valid=0, ctr=2'b01, target and tag=0.
  - Branch_Count = Mispredict_Count = 0.
  - Pred_Taken=0; Pred_Target=IF_PC+4; Mispredict=0 when EX_Branch=0.
- Reset takes effect immediately, mid-operation included. Any training in flight that cycle is discarded.
- Prediction latency is 0 cycles (combinational from IF_PC). Resolve latency is 0 cycles (combinational from EX inputs).
- Table state becomes visible to IF the cycle after the training edge.
- Same-index IF lookup and EX update in one cycle: IF sees the pre-update contents. No bypass.
- Aliasing: two branches sharing an index with different tags replace each other only on a taken miss. A not-taken branch never evicts.
- Stats are sampled once per branch. A branch held in EX by EX_Stall is counted once, on its unstalled cycle.

## Test plan
- Reset, then IF_PC=0x100 -> Pred_Taken=0, Pred_Target=0x104. Both counters read 0.
- EX branch at EX_PC=0x100, Branch_Taken=1, PC_Plus_Imm=0x80, EX_Pred_Taken=0 -> Mispredict=1, Redirect_PC=0x80. Next cycle IF_PC=0x100 gives Pred_Taken=1, Pred_Target=0x80, ctr=2. Counts are 1/1.
- Train 0x100 taken ×3 (correct predictions), then not taken once:
  - ctr saturates at 3, then drops to 2; prediction stays taken.
  - Second not-taken -> ctr=1, Pred_Taken=0.
  - The first not-taken asserts Mispredict with Redirect_PC=0x104.
- Taken branch with matching direction but wrong target (EX_Pred_Target=0x80, PC_Plus_Imm=0x90) -> Mispredict=1, Redirect_PC=0x90; stored target becomes 0x90.
- Alias: 0x100 trained taken, then a taken miss at 0x140 (same index, different tag) -> entry replaced. 0x100 then predicts not taken; 0x140 predicts taken with ctr=2.
- EX_Stall=1 with EX_Branch=1 for 3 cycles, then released -> table and counters change only once. Assert rst mid-sequence -> all outputs return to reset values asynchronously.
